plot_tile_map: RTL and testbench

//  Receiving end of the pixel-plot interface (x, y, colour, plot) that the drawing FSMs drive into vga_adapter.

---
 rtl/plot_tile_map.sv | 182 ++++++++++++++++++
 tb/tb_plot_tile_map.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_tile_map.sv
// Tile-granular shadow of the screen, built by snooping the pixel-plot stream.
// Game logic reads tiles back through a pipelined valid/ready query port.
module plot_tile_map #(
  parameter int               XSCREEN = 160,
  parameter int               YSCREEN = 120,
  parameter int               TILE    = 10,
  parameter int               CBITS   = 3,
  parameter logic [CBITS-1:0] BG      = '0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [7:0]       x,
  input  logic [6:0]       y,
  input  logic [CBITS-1:0] colour,
  input  logic             plot,
  input  logic             clr_req,
  output logic             busy,
  input  logic             q_valid,
  input  logic [3:0]       q_tx,
  input  logic [3:0]       q_ty,
  output logic             q_ready,
  output logic             r_valid,
  output logic [CBITS-1:0] r_colour,
  output logic             r_hit
);

  localparam int TX = XSCREEN / TILE;
  localparam int TY = YSCREEN / TILE;
  localparam int NT = TX * TY;

  // Handshake: a query is taken on any cycle where q_valid && q_ready; its
  // response appears as a single-cycle r_valid pulse on the following cycle.
  // q_ready is the inverse of busy, so no query is ever taken during a sweep.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic [CBITS-1:0] mem_q [NT];
  logic             mem_we;
  logic [7:0]       mem_waddr;
  logic [CBITS-1:0] mem_wdata;

  logic [7:0] px_tile;
  logic [7:0] py_tile;
  logic       plot_onscreen;
  logic       plot_origin;
  logic       plot_write;
  logic [7:0] plot_idx;

  logic             q_in_range;
  logic [7:0]       q_idx;
  logic             q_accept;
  logic [CBITS-1:0] q_rdata;

  logic             r_valid_q, r_valid_d;
  logic [CBITS-1:0] r_colour_q, r_colour_d;
  logic             r_hit_q, r_hit_d;

  // Only the top-left pixel of each tile updates the map.
  always_comb begin
    px_tile       = 8'(32'(x) / TILE);
    py_tile       = 8'(32'(y) / TILE);
    plot_onscreen = (32'(x) < XSCREEN) && (32'(y) < YSCREEN);
    plot_origin   = (32'(x) % TILE == 0) && (32'(y) % TILE == 0);
    plot_idx      = 8'(32'(py_tile) * TX + 32'(px_tile));
  end

  always_comb begin
    q_in_range = (32'(q_tx) < TX) && (32'(q_ty) < TY);
    q_idx      = 8'(32'(q_ty) * TX + 32'(q_tx));
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; a clear request mid-sweep is deliberately ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == 8'(NT - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: the sweep owns the write port, otherwise qualifying plots do.
  always_comb begin
    busy       = (state_q == S_CLEAR);
    plot_write = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = BG;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = BG;
    end else if (plot && plot_onscreen && plot_origin) begin
      plot_write = 1'b1;
      mem_we     = 1'b1;
      mem_waddr  = plot_idx;
      mem_wdata  = colour;
    end
  end

  // Tile storage has no reset; the sweep after reset initialises it.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign q_ready  = ~busy;
  assign q_accept = q_valid & q_ready;

  // Out-of-range tiles never touch the array; a same-cycle plot wins.
  always_comb begin
    q_rdata = BG;
    if (q_in_range) begin
      if (plot_write && (plot_idx == q_idx)) begin
        q_rdata = colour;
      end else begin
        q_rdata = mem_q[q_idx];
      end
    end
  end

  always_comb begin
    r_valid_d  = q_accept;
    r_colour_d = r_colour_q;
    r_hit_d    = r_hit_q;
    if (q_accept) begin
      r_colour_d = q_rdata;
      r_hit_d    = (q_rdata != BG);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid_q  <= 1'b0;
      r_colour_q <= BG;
      r_hit_q    <= 1'b0;
    end else begin
      r_valid_q  <= r_valid_d;
      r_colour_q <= r_colour_d;
      r_hit_q    <= r_hit_d;
    end
  end

  assign r_valid  = r_valid_q;
  assign r_colour = r_colour_q;
  assign r_hit    = r_hit_q;

endmodule

// File: tb/tb_plot_tile_map.sv
// Bench for plot_tile_map: vector table of plots/queries, hand sequences for
// bypass, clear and reset-during-sweep, responses checked from a queue.
module tb_plot_tile_map;

  localparam int CBITS = 3;
  localparam int NT    = 192;
  localparam int SWEEP = 192;

  logic             clock = 1'b0;
  logic             resetn;
  logic [7:0]       x;
  logic [6:0]       y;
  logic [CBITS-1:0] colour;
  logic             plot;
  logic             clr_req;
  logic             busy;
  logic             q_valid;
  logic [3:0]       q_tx;
  logic [3:0]       q_ty;
  logic             q_ready;
  logic             r_valid;
  logic [CBITS-1:0] r_colour;
  logic             r_hit;

  plot_tile_map dut (
    .clock   (clock),
    .resetn  (resetn),
    .x       (x),
    .y       (y),
    .colour  (colour),
    .plot    (plot),
    .clr_req (clr_req),
    .busy    (busy),
    .q_valid (q_valid),
    .q_tx    (q_tx),
    .q_ty    (q_ty),
    .q_ready (q_ready),
    .r_valid (r_valid),
    .r_colour(r_colour),
    .r_hit   (r_hit)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: {hit, colour} with the cycle the response is due.
  logic [3:0]       exp_q[$];
  int               due_q[$];
  logic [CBITS-1:0] model[NT];
  logic [3:0]       rsp_exp;

  typedef struct {
    bit         is_plot;
    int         a;
    int         b;
    logic [2:0] c;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare responses on the falling edge.
  always @(negedge clock) begin
    if (resetn) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        rsp_exp = exp_q.pop_front();
        void'(due_q.pop_front());
        check("r_valid", {31'b0, r_valid}, 32'd1);
        check("response", {28'b0, r_hit, r_colour}, {28'b0, rsp_exp});
      end else if (r_valid) begin
        check("spurious_r_valid", {31'b0, r_valid}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    plot    = 1'b0;
    q_valid = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic do_plot(input int px, input int py, input logic [2:0] c);
    x      = 8'(px);
    y      = 7'(py);
    colour = c;
    plot   = 1'b1;
    if (px < 160 && py < 120 && px % 10 == 0 && py % 10 == 0 && !busy)
      model[(py / 10) * 16 + px / 10] = c;
  endtask

  task automatic expect_query(input int tx, input int ty, input logic [3:0] e);
    q_tx    = 4'(tx);
    q_ty    = 4'(ty);
    q_valid = 1'b1;
    check("q_ready_at_query", {31'b0, q_ready}, 32'd1);
    exp_q.push_back(e);
    due_q.push_back(cyc + 1);
  endtask

  function automatic logic [3:0] model_exp(input int tx, input int ty);
    logic [2:0] c;
    if (tx >= 16 || ty >= 12) return 4'b0000;
    c = model[ty * 16 + tx];
    return {c != 3'b000, c};
  endfunction

  // Counts falling edges with busy high from now; bounded.
  task automatic run_busy(input string name);
    int  n;
    bit  rdy_bad;
    n       = 0;
    rdy_bad = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (!busy) break;
      n++;
      if (q_ready) rdy_bad = 1'b1;
    end
    check(name, n, SWEEP);
    check({name, "_q_ready_low"}, {31'b0, rdy_bad}, 32'd0);
    check({name, "_q_ready_after"}, {31'b0, q_ready}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic scan_all();
    for (int ty = 0; ty < 12; ty++) begin
      for (int tx = 0; tx < 16; tx++) begin
        expect_query(tx, ty, model_exp(tx, ty));
        tick();
      end
    end
    q_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clock);
    check({name, "_busy"}, {31'b0, busy}, 32'd1);
    check({name, "_q_ready"}, {31'b0, q_ready}, 32'd0);
    check({name, "_r_valid"}, {31'b0, r_valid}, 32'd0);
    check({name, "_r_colour"}, {29'b0, r_colour}, 32'd0);
    check({name, "_r_hit"}, {31'b0, r_hit}, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b0,   3,   4, 3'b000, 4'b0000};
    tbl[1]  = '{1'b1,  30,  40, 3'b010, 4'b0000};
    tbl[2]  = '{1'b0,   3,   4, 3'b000, 4'b1010};
    tbl[3]  = '{1'b1,  31,  40, 3'b111, 4'b0000};
    tbl[4]  = '{1'b0,   3,   4, 3'b000, 4'b1010};
    tbl[5]  = '{1'b0,  15,  12, 3'b000, 4'b0000};
    tbl[6]  = '{1'b0,   0,  15, 3'b000, 4'b0000};
    tbl[7]  = '{1'b1, 159, 119, 3'b011, 4'b0000};
    tbl[8]  = '{1'b0,  15,  11, 3'b000, 4'b0000};
    tbl[9]  = '{1'b1, 150, 110, 3'b110, 4'b0000};
    tbl[10] = '{1'b0,  15,  11, 3'b000, 4'b1110};
    tbl[11] = '{1'b1,   0,   0, 3'b001, 4'b0000};
    tbl[12] = '{1'b0,   0,   0, 3'b000, 4'b1001};
    tbl[13] = '{1'b1,   5,   0, 3'b111, 4'b0000};
    tbl[14] = '{1'b0,   0,   0, 3'b000, 4'b1001};
    tbl[15] = '{1'b1, 250,   0, 3'b111, 4'b0000};
    tbl[16] = '{1'b0,   9,   1, 3'b000, 4'b0000};
    tbl[17] = '{1'b1, 160,   0, 3'b111, 4'b0000};
    tbl[18] = '{1'b0,   0,   1, 3'b000, 4'b0000};
    tbl[19] = '{1'b1,  40,  15, 3'b111, 4'b0000};
    tbl[20] = '{1'b0,   4,   1, 3'b000, 4'b0000};

    for (int i = 0; i < NT; i++) model[i] = 3'b000;
    resetn = 1'b0;
    x = '0; y = '0; colour = '0; q_tx = '0; q_ty = '0;
    idle_inputs();

    // Reset and initial sweep
    tick();
    tick();
    check_reset_state("reset");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    run_busy("reset_sweep_len");

    // Vector table: plots and single queries
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].is_plot) begin
        do_plot(tbl[i].a, tbl[i].b, tbl[i].c);
        tick();
        plot = 1'b0;
      end else begin
        expect_query(tbl[i].a, tbl[i].b, tbl[i].exp);
        tick();
        q_valid = 1'b0;
      end
    end
    tick();

    // Write-first bypass on the same tile in the same cycle
    do_plot(50, 20, 3'b101);
    expect_query(5, 2, 4'b1101);
    tick();
    plot = 1'b0;
    q_valid = 1'b0;
    expect_query(5, 2, 4'b1101);
    tick();
    q_valid = 1'b0;

    // Off-screen plot leaves the whole map unchanged
    do_plot(160, 0, 3'b111);
    tick();
    plot = 1'b0;
    scan_all();

    // Clear with a same-cycle query, and a plot dropped during the sweep
    do_plot(0, 0, 3'b111);
    tick();
    do_plot(150, 110, 3'b111);
    tick();
    plot = 1'b0;
    clr_req = 1'b1;
    expect_query(15, 11, 4'b1111);
    tick();
    clr_req = 1'b0;
    q_valid = 1'b0;
    for (int i = 0; i < NT; i++) model[i] = 3'b000;
    fork
      run_busy("clear_sweep_len");
      begin
        do_plot(0, 0, 3'b111);
        tick();
        plot = 1'b0;
      end
    join
    expect_query(0, 0, 4'b0000);
    tick();
    expect_query(15, 11, 4'b0000);
    tick();
    q_valid = 1'b0;
    tick();

    // Reset asserted part-way through a sweep
    do_plot(70, 30, 3'b110);
    tick();
    plot = 1'b0;
    expect_query(7, 3, 4'b1110);
    tick();
    q_valid = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < NT; i++) model[i] = 3'b000;
    repeat (100) tick();
    resetn = 1'b0;
    check_reset_state("midsweep_reset");
    tick();
    tick();
    resetn = 1'b1;
    run_busy("restart_sweep_len");
    scan_all();

    tick();
    tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
